// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared constants for the nibble-serial add/sub sequencer:
// FSM state encoding, slice width and ADD/SUB opcodes.
package nibble_serial_addsub_ctrl_pkg;

   localparam int NIB_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/nibble_addsub4.sv
// Combinational 4-bit ripple add/sub slice built from four full adders.
// Ports: a, b, sub (invert b), cin -> s, cout, c3 (carry into bit 3).
module nibble_addsub4
   import nibble_serial_addsub_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout,
   output logic             c3
);

   logic [NIB_W-1:0] bx;
   logic [NIB_W:0]   c;

   assign bx   = b ^ {NIB_W{sub}};
   assign c[0] = cin;

   for (genvar i = 0; i < NIB_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
   end

   assign cout = c[NIB_W];
   assign c3   = c[NIB_W-1];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/sub sequencer reusing one 4-bit slice, one nibble per clock.
// Ports: clk, rst_n, start, sub, op_a, op_b -> busy, done, result, cout
// (+ ovf when NIBBLE_SERIAL_ADDSUB_OVF_EN is defined).
module nibble_serial_addsub_ctrl
   import nibble_serial_addsub_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W = NIB_W * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int IDXW = $clog2(NIBBLES);
   localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

   state_t state, state_nx;

   logic [W-1:0]     a_q, b_q;
   logic             sub_q;
   logic             carry_q;
   logic [IDXW-1:0]  idx;
   logic [NIB_W-1:0] sl_s;
   logic             sl_co;
   logic             last;

`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
   logic sl_c3;
`else
   logic sl_c3_unused;
`endif

   nibble_addsub4 u_slice (
      .a    (a_q[idx*NIB_W +: NIB_W]),
      .b    (b_q[idx*NIB_W +: NIB_W]),
      .sub  (sub_q),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_co),
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
      .c3   (sl_c3)
`else
      .c3   (sl_c3_unused)
`endif
   );

   assign last = (idx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         S_IDLE: if (start) state_nx = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (last) state_nx = S_DONE;
         end
         S_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= OP_ADD;
         carry_q <= 1'b0;
         idx     <= '0;
         result  <= '0;
         cout    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         if (state == S_IDLE && start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= sub;
            // carry-in of 1 completes the two's complement of B
            carry_q <= (sub == OP_SUB);
            idx     <= '0;
         end
         if (state == S_RUN) begin
            result[idx*NIB_W +: NIB_W] <= sl_s;
            carry_q <= sl_co;
            if (last) begin
               cout <= sl_co;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
               ovf  <= sl_co ^ sl_c3;
`endif
            end else begin
               idx <= idx + IDXW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl (NIBBLES=4).
// Optional ovf checks follow NIBBLE_SERIAL_ADDSUB_OVF_EN.
module tb_nibble_serial_addsub_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        cout;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
   logic        ovf;
`endif

   int nvec = 0;
   int nerr = 0;

   nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result),
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
      .cout   (cout),
      .ovf    (ovf)
`else
      .cout   (cout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic s,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic c,
                         input logic v);
      int k;
      int nb;
      k  = 0;
      nb = 0;
      @(negedge clk);
      start = 1'b1;
      sub   = s;
      op_a  = a;
      op_b  = b;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) nb++;
      while (!done && k < 12) begin
         @(posedge clk); #1;
         k++;
         if (busy) nb++;
      end
      // done shows up after the edge that writes the last nibble
      check({tag, ":lat"}, k, 4);
      check({tag, ":busy"}, nb, 5);
      check({tag, ":res"}, result, r);
      check({tag, ":cout"}, cout, c);
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
      check({tag, ":ovf"}, ovf, v);
`else
      if (v) nb = nb;
`endif
      @(posedge clk); #1;
      check({tag, ":done1"}, done, 0);
      check({tag, ":idle"}, busy, 0);
      check({tag, ":hold"}, result, r);
   endtask

   initial begin
      int nd;
      logic [15:0] rcap;
      logic        ccap;
      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #12;
      check("rst:busy", busy, 0);
      check("rst:done", done, 0);
      check("rst:res", result, 0);
      check("rst:cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add1", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
      run_op("sub1", 1'b1, 16'h0008, 16'h0003, 16'h0005, 1'b1, 1'b0);
      run_op("sub2", 1'b1, 16'h0002, 16'h0005, 16'hFFFD, 1'b0, 1'b0);
      run_op("ripl", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
      run_op("ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

      // second start during RUN must be ignored
      @(negedge clk);
      start = 1'b1;
      sub   = 1'b0;
      op_a  = 16'h0001;
      op_b  = 16'h0002;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      op_a  = 16'h1111;
      sub   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nd   = 0;
      rcap = '0;
      ccap = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            nd++;
            rcap = result;
            ccap = cout;
         end
         @(posedge clk); #1;
      end
      check("ign:ndone", nd, 1);
      check("ign:res", rcap, 16'h0003);
      check("ign:cout", ccap, 0);

      // reset in the second RUN cycle
      @(negedge clk);
      start = 1'b1;
      sub   = 1'b0;
      op_a  = 16'h1234;
      op_b  = 16'h0FCD;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mrst:busy", busy, 0);
      check("mrst:done", done, 0);
      check("mrst:res", result, 0);
      check("mrst:cout", cout, 0);
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      check("mrst:nodone", nd, 0);
      run_op("post", 1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0);

      // back-to-back: run_op returns in the cycle after done
      run_op("b2b1", 1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0);
      run_op("b2b2", 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
